// File: rtl/tt_lut_pkg.sv
// Shared types and helpers for the reprogrammable truth-table evaluator.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package tt_lut_pkg;

   // Config loader states: waiting for a first word, collecting words, committing.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } cfg_state_e;

   // Power-on table for the default 4-input configuration.
   localparam logic [15:0] DEFAULT_RST_TT = 16'h5215;

   // Number of config words needed to fill one table.
   function automatic int calc_nwords(input int tt_w, input int word_w);
      return tt_w / word_w;
   endfunction

   // Width of a channel index; at least one bit even for a single channel.
   function automatic int calc_ch_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/tt_lut_eval_cfg_loader.sv
// Word-serial table loader: assembles a shadow table and raises a commit strobe.
// Latency: shadow committed in the cycle after the last word is accepted.
// Backpressure: cfg_ready drops only during the single COMMIT cycle.
module tt_cfg_loader
   import tt_lut_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int N_CH   = 2,
   parameter int WORD_W = 8,
   localparam int TT_W   = 2 ** N_IN,
   localparam int NWORDS = calc_nwords(TT_W, WORD_W),
   localparam int CH_W   = calc_ch_w(N_CH),
   localparam int WC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [WORD_W-1:0] cfg_word,
   input  logic              cfg_last,
   output logic              cfg_err,
   output logic              commit,
   output logic [CH_W-1:0]   commit_ch,
   output logic [TT_W-1:0]   commit_tt
);

   localparam logic [WC_W-1:0] LAST_IDX = WC_W'(NWORDS - 1);

   cfg_state_e      state_q, state_d;
   logic [WC_W-1:0] word_cnt_q, word_cnt_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic [TT_W-1:0] shadow_q, shadow_d;
   logic            err_q, err_d;

   logic            cfg_acc;
   logic [WC_W-1:0] word_idx;
   logic            final_word;
   logic            seq_err;
   logic            ch_err;
   logic            ch_out_of_range;

   assign cfg_ready = (state_q != COMMIT);
   assign cfg_acc   = cfg_valid && cfg_ready;

   // A first word always lands in slot 0; later words follow the running count.
   assign word_idx   = (state_q == IDLE) ? '0 : word_cnt_q;
   assign final_word = (word_idx == LAST_IDX);

   // cfg_last must coincide exactly with the final slot, neither early nor missing.
   assign seq_err = (cfg_last != final_word);

   // Channel numbers beyond N_CH only matter when N_CH is not a power of two.
   assign ch_out_of_range = ({1'b0, cfg_ch} >= (CH_W + 1)'(N_CH));
   assign ch_err = (state_q == IDLE) ? ch_out_of_range : (cfg_ch != ch_q);

   // Next-state logic: collect words, abort on any protocol error, commit once.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      ch_d       = ch_q;
      shadow_d   = shadow_q;
      err_d      = 1'b0;
      unique case (state_q)
         IDLE, LOAD: begin
            if (cfg_acc) begin
               if (seq_err || ch_err) begin
                  // Drop the partial table; the active tables are never touched here.
                  err_d      = 1'b1;
                  shadow_d   = '0;
                  word_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  if (state_q == IDLE) begin
                     ch_d     = cfg_ch;
                     shadow_d = '0;
                  end
                  for (int w = 0; w < NWORDS; w++) begin
                     if (word_idx == WC_W'(w)) begin
                        shadow_d[w*WORD_W +: WORD_W] = cfg_word;
                     end
                  end
                  if (cfg_last) begin
                     word_cnt_d = '0;
                     state_d    = COMMIT;
                  end else begin
                     word_cnt_d = word_idx + 1'b1;
                     state_d    = LOAD;
                  end
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d    = IDLE;
            word_cnt_d = '0;
         end
      endcase
   end

   // Loader state register; reset abandons any load in flight without an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         ch_q       <= '0;
         shadow_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         ch_q       <= ch_d;
         shadow_q   <= shadow_d;
         err_q      <= err_d;
      end
   end

   assign cfg_err   = err_q;
   assign commit    = (state_q == COMMIT);
   assign commit_ch = ch_q;
   assign commit_tt = shadow_q;

endmodule

// File: rtl/tt_lut_eval.sv
// N_IN-input / N_CH-output truth-table evaluator with run-time reloadable tables.
// Latency: 1 cycle accept-to-out_valid; a new table is live the cycle after COMMIT.
// Backpressure: in_ready = !out_valid || out_ready, held low for the COMMIT cycle.
module tt_lut_eval
   import tt_lut_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int N_CH   = 2,
   parameter int WORD_W = 8,
   parameter logic [(2**N_IN)-1:0] RST_TT = DEFAULT_RST_TT,
   localparam int TT_W  = 2 ** N_IN,
   localparam int CH_W  = calc_ch_w(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN-1:0]   in_vec,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_CH-1:0]   out_bits,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [WORD_W-1:0] cfg_word,
   input  logic              cfg_last,
   output logic              cfg_err,
   output logic [15:0]       eval_cnt
);

   logic [TT_W-1:0] tbl_q [N_CH];

   logic            commit;
   logic [CH_W-1:0] commit_ch;
   logic [TT_W-1:0] commit_tt;

   logic            out_valid_q;
   logic [N_CH-1:0] out_bits_q;
   logic [15:0]     eval_cnt_q;

   logic            in_acc;
   logic            out_xfer;

   tt_cfg_loader #(
      .N_IN   (N_IN),
      .N_CH   (N_CH),
      .WORD_W (WORD_W)
   ) u_loader (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_word  (cfg_word),
      .cfg_last  (cfg_last),
      .cfg_err   (cfg_err),
      .commit    (commit),
      .commit_ch (commit_ch),
      .commit_tt (commit_tt)
   );

   // Stalling input during COMMIT means no accept can straddle old and new tables.
   assign in_ready = (!out_valid_q || out_ready) && !commit;
   assign in_acc   = in_valid && in_ready;
   assign out_xfer = out_valid_q && out_ready;

   // Active tables: whole-table replace on commit, so readers never see a mix.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CH; c++) begin
            tbl_q[c] <= RST_TT;
         end
      end else if (commit) begin
         for (int c = 0; c < N_CH; c++) begin
            if (commit_ch == CH_W'(c)) begin
               tbl_q[c] <= commit_tt;
            end
         end
      end
   end

   // Output register: loads on accept, otherwise holds until downstream takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_bits_q  <= '0;
      end else if (in_acc) begin
         out_valid_q <= 1'b1;
         for (int c = 0; c < N_CH; c++) begin
            out_bits_q[c] <= tbl_q[c][in_vec];
         end
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Completed-transfer counter, pinned at all-ones once it gets there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eval_cnt_q <= '0;
      end else if (out_xfer && (eval_cnt_q != 16'hFFFF)) begin
         eval_cnt_q <= eval_cnt_q + 16'd1;
      end
   end

   assign out_valid = out_valid_q;
   assign out_bits  = out_bits_q;
   assign eval_cnt  = eval_cnt_q;

endmodule

// File: tb/tb_tt_lut_eval.sv
// Testbench for tt_lut_eval: directed vectors, load/error/commit sequences, random traffic.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that point.
// Random phase checks handshakes and data against a table-level model with a scoreboard queue.
module tb_tt_lut_eval;

   localparam int N_IN = 4;
   localparam int N_CH = 2;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      in_vec;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      out_bits;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [0:0]      cfg_ch;
   logic [7:0]      cfg_word;
   logic            cfg_last;
   logic            cfg_err;
   logic [15:0]     eval_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt = 0;

   logic [15:0] tbl_m [N_CH];

   typedef struct {
      logic [3:0] vec;
      logic [1:0] exp;
   } vec_t;

   vec_t vtab [8];

   tt_lut_eval #(
      .N_IN   (N_IN),
      .N_CH   (N_CH),
      .WORD_W (8),
      .RST_TT (16'h5215)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_word  (cfg_word),
      .cfg_last  (cfg_last),
      .cfg_err   (cfg_err),
      .eval_cnt  (eval_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] model_eval(input logic [3:0] v);
      return {tbl_m[1][v], tbl_m[0][v]};
   endfunction

   task automatic cfg_put(input logic ch, input logic [7:0] w, input logic last);
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_word  = w;
      cfg_last  = last;
      tick();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
   endtask

   task automatic eval_one(input logic [3:0] v, input logic [1:0] e, input string nm);
      in_valid  = 1'b1;
      in_vec    = v;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check({nm, "_valid"}, 32'(out_valid), 32'd1);
      check(nm, 32'(out_bits), 32'(e));
      tick();
      exp_cnt++;
   endtask

   logic [1:0]  exp_q [$];
   logic        commit_now;
   logic        ld_ch;
   int          ld_idx;
   logic [15:0] ld_tt;
   logic        tail;
   logic        exp_rdy;
   int          low_cnt;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
      cfg_valid = 1'b0; cfg_ch = '0; cfg_word = '0; cfg_last = 1'b0;
      tbl_m[0] = 16'h5215; tbl_m[1] = 16'h5215;

      vtab[0] = '{vec: 4'h0, exp: 2'b11};
      vtab[1] = '{vec: 4'h9, exp: 2'b11};
      vtab[2] = '{vec: 4'h3, exp: 2'b00};
      vtab[3] = '{vec: 4'h2, exp: 2'b11};
      vtab[4] = '{vec: 4'h4, exp: 2'b11};
      vtab[5] = '{vec: 4'h1, exp: 2'b00};
      vtab[6] = '{vec: 4'hF, exp: 2'b00};
      vtab[7] = '{vec: 4'hC, exp: 2'b11};

      #23 rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_bits",  32'(out_bits),  0);
      check("rst_eval_cnt",  32'(eval_cnt),  0);
      check("rst_cfg_err",   32'(cfg_err),   0);
      check("rst_in_ready",  32'(in_ready),  1);
      check("rst_cfg_ready", 32'(cfg_ready), 1);

      // Back-to-back vectors on the reset tables
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_vec   = vtab[i].vec;
         #1;
         check($sformatf("tab_in_ready_%0d", i), 32'(in_ready), 1);
         tick();
         check($sformatf("tab_valid_%0d", i), 32'(out_valid), 1);
         check($sformatf("tab_bits_%0d", i), 32'(out_bits), 32'(vtab[i].exp));
      end
      in_valid = 1'b0;
      tick();
      exp_cnt = 8;
      check("tab_drained", 32'(out_valid), 0);
      check("tab_eval_cnt", 32'(eval_cnt), 32'(exp_cnt));

      // Load ch1 = 16'h00FF
      cfg_put(1'b1, 8'hFF, 1'b0);
      check("ld_err_w0", 32'(cfg_err), 0);
      cfg_put(1'b1, 8'h00, 1'b1);
      check("ld_commit_in_ready", 32'(in_ready), 0);
      check("ld_commit_cfg_ready", 32'(cfg_ready), 0);
      tick();
      check("ld_after_in_ready", 32'(in_ready), 1);
      check("ld_after_cfg_ready", 32'(cfg_ready), 1);
      tbl_m[1] = 16'h00FF;
      eval_one(4'h3, 2'b10, "ld_vec3");
      eval_one(4'h8, 2'b00, "ld_vec8");

      // Early last on word 0
      cfg_put(1'b0, 8'hAA, 1'b1);
      check("err_early_pulse", 32'(cfg_err), 1);
      tick();
      check("err_early_once", 32'(cfg_err), 0);
      check("err_early_no_commit", 32'(in_ready), 1);
      eval_one(4'h2, 2'b11, "err_early_vec2");

      // Channel changes mid-load
      cfg_put(1'b0, 8'h00, 1'b0);
      check("err_ch_w0", 32'(cfg_err), 0);
      cfg_put(1'b1, 8'h00, 1'b1);
      check("err_ch_pulse", 32'(cfg_err), 1);
      check("err_ch_no_commit", 32'(in_ready), 1);
      tick();
      check("err_ch_once", 32'(cfg_err), 0);
      eval_one(4'h0, 2'b11, "err_ch_vec0");

      // Final word without last
      cfg_put(1'b1, 8'h00, 1'b0);
      cfg_put(1'b1, 8'h00, 1'b0);
      check("err_nolast_pulse", 32'(cfg_err), 1);
      tick();
      check("err_nolast_once", 32'(cfg_err), 0);
      eval_one(4'h3, 2'b10, "err_nolast_vec3");

      // Backpressure: 3 stalled cycles, then drain at full rate
      out_ready = 1'b1; in_valid = 1'b1; in_vec = 4'h9;
      tick();
      out_ready = 1'b0; in_vec = 4'h3;
      #1;
      check("bp_in_ready_low", 32'(in_ready), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp_hold_valid_%0d", i), 32'(out_valid), 1);
         check($sformatf("bp_hold_bits_%0d", i), 32'(out_bits), 32'(2'b01));
         check($sformatf("bp_hold_rdy_%0d", i), 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_rdy", 32'(in_ready), 1);
      tick();
      check("bp_b_bits", 32'(out_bits), 32'(2'b10));
      in_vec = 4'h4;
      tick();
      check("bp_c_bits", 32'(out_bits), 32'(2'b11));
      in_valid = 1'b0;
      tick();
      check("bp_drained", 32'(out_valid), 0);
      exp_cnt += 3;
      check("bp_eval_cnt", 32'(eval_cnt), 32'(exp_cnt));

      // Stream vector 0 across the commit of ch0 = 16'h0000
      low_cnt = 0;
      in_valid = 1'b1; in_vec = 4'h0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cfg_valid = (i == 1) || (i == 2);
         cfg_ch    = 1'b0;
         cfg_word  = 8'h00;
         cfg_last  = (i == 2);
         #1;
         if (!in_ready) low_cnt++;
         check($sformatf("cm_in_ready_%0d", i), 32'(in_ready), 32'(i != 3));
         tick();
         check($sformatf("cm_valid_%0d", i), 32'(out_valid), 32'(i != 3));
         if (i != 3)
            check($sformatf("cm_bit0_%0d", i), 32'(out_bits[0]), 32'(i < 3));
      end
      cfg_valid = 1'b0; cfg_last = 1'b0; in_valid = 1'b0;
      tick();
      check("cm_gap_cycles", 32'(low_cnt), 1);
      tbl_m[0] = 16'h0000;
      exp_cnt += 7;

      // Randomized traffic and reloads against the model
      commit_now = 1'b0; ld_ch = 1'b0; ld_idx = 0; ld_tt = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         tail      = (cyc >= 590);
         in_valid  = !tail && ($urandom_range(0, 3) != 0);
         in_vec    = 4'($urandom);
         out_ready = tail || ($urandom_range(0, 3) != 0);
         cfg_valid = 1'b0;
         cfg_last  = 1'b0;
         if (!commit_now && (tail ? (ld_idx != 0) : ($urandom_range(0, 2) == 0))) begin
            cfg_valid = 1'b1;
            cfg_ch    = ld_ch;
            cfg_word  = 8'($urandom);
            cfg_last  = (ld_idx == 1);
         end
         #1;
         exp_rdy = ((exp_q.size() == 0) || out_ready) && !commit_now;
         check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
         check("rnd_cfg_ready", 32'(cfg_ready), 32'(!commit_now));
         check("rnd_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         check("rnd_cfg_err", 32'(cfg_err), 0);
         if (exp_q.size() != 0) begin
            check("rnd_out_bits", 32'(out_bits), 32'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
         end
         if (in_valid && exp_rdy) begin
            exp_q.push_back(model_eval(in_vec));
            exp_cnt++;
         end
         commit_now = 1'b0;
         if (cfg_valid) begin
            ld_tt[ld_idx*8 +: 8] = cfg_word;
            if (ld_idx == 1) begin
               tbl_m[ld_ch] = ld_tt;
               commit_now   = 1'b1;
               ld_idx       = 0;
               ld_ch        = 1'($urandom_range(0, 1));
            end else begin
               ld_idx = 1;
            end
         end
         tick();
      end
      cfg_valid = 1'b0; in_valid = 1'b0;
      check("rnd_eval_cnt", 32'(eval_cnt), 32'(exp_cnt));

      // Reset in the middle of a ch1 load
      cfg_put(1'b1, 8'h0F, 1'b0);
      check("rstld_err_w0", 32'(cfg_err), 0);
      #2 rst_n = 1'b0;
      #1;
      check("rstld_cfg_err", 32'(cfg_err), 0);
      check("rstld_eval_cnt", 32'(eval_cnt), 0);
      check("rstld_out_valid", 32'(out_valid), 0);
      #3 rst_n = 1'b1;
      tick();
      check("rstld_err_after", 32'(cfg_err), 0);
      tbl_m[0] = 16'h5215; tbl_m[1] = 16'h5215;
      exp_cnt = 0;
      cfg_put(1'b0, 8'hF0, 1'b0);
      check("rstld_new_w0_err", 32'(cfg_err), 0);
      cfg_put(1'b0, 8'h0F, 1'b1);
      check("rstld_new_w1_err", 32'(cfg_err), 0);
      check("rstld_new_commit", 32'(in_ready), 0);
      tick();
      tbl_m[0] = 16'h0FF0;
      eval_one(4'h1, 2'b00, "rstld_vec1");
      eval_one(4'h9, 2'b11, "rstld_vec9");
      eval_one(4'hC, 2'b10, "rstld_vecC");
      check("rstld_model_vecC", 32'(model_eval(4'hC)), 32'(2'b10));
      check("rstld_final_cnt", 32'(eval_cnt), 32'(exp_cnt));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
